// File: rtl/pattern_gen_pkg.sv
//------------------------------------------------------------------------------
// pattern_gen_pkg : shared encodings for the serial pattern generator
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package pattern_gen_pkg;

  localparam logic [1:0] MODE_ROTATE  = 2'd0;
  localparam logic [1:0] MODE_ONESHOT = 2'd1;
  localparam logic [1:0] MODE_REPEAT  = 2'd2;

  localparam logic DIR_MSB_FIRST = 1'b0;
  localparam logic DIR_LSB_FIRST = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/rotate_reg.sv
//------------------------------------------------------------------------------
// rotate_reg : WIDTH-bit parallel-load bidirectional rotate register
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rotate_reg
  import pattern_gen_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dir,
  input  logic             shift_en,
  output logic             head,
  output logic             next_head
);

  logic [WIDTH-1:0] reg_q;
  logic [WIDTH-1:0] reg_d;

  always_comb begin
    reg_d = reg_q;
    if (load) begin
      reg_d = load_value;
    end else if (shift_en) begin
      if (dir == DIR_LSB_FIRST) begin
        reg_d = {reg_q[0], reg_q[WIDTH-1:1]};
      end else begin
        reg_d = {reg_q[WIDTH-2:0], reg_q[WIDTH-1]};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_q <= '0;
    end else begin
      reg_q <= reg_d;
    end
  end

  // next_head is what head becomes after one rotation in the current direction
  assign head      = (dir == DIR_LSB_FIRST) ? reg_q[0] : reg_q[WIDTH-1];
  assign next_head = (dir == DIR_LSB_FIRST) ? reg_q[1] : reg_q[WIDTH-2];

endmodule

`default_nettype wire

// File: rtl/pattern_generator.sv
//------------------------------------------------------------------------------
// pattern_generator : serial pattern generator with rotate/oneshot/repeat modes
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pattern_generator
  import pattern_gen_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     LOAD,
  input  logic [WIDTH-1:0]         LOADED_VALUE,
  input  logic [1:0]               MODE,
  input  logic                     DIR,
  input  logic [CNT_W-1:0]         REPEAT,
  input  logic                     EN,
  output logic                     OUT,
  output logic                     BUSY,
  output logic                     DONE,
  output logic [$clog2(WIDTH)-1:0] BIT_IDX
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic             out_q, out_d;
  logic             done_q, done_d;
  logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
  logic [CNT_W-1:0] pass_q, pass_d;
  logic [1:0]       mode_q, mode_d;
  logic             dir_q, dir_d;
  logic [CNT_W-1:0] rep_q, rep_d;

  logic             advance;
  logic             head_unused;
  logic             next_head;
  logic [CNT_W-1:0] rep_max;

  assign advance = (state_q == ST_RUN) && EN && !LOAD;
  assign rep_max = (rep_q == '0) ? CNT_W'(1) : rep_q;

  rotate_reg #(
    .WIDTH (WIDTH)
  ) u_rotate_reg (
    .clk        (CLK),
    .rst        (RST),
    .load       (LOAD),
    .load_value (LOADED_VALUE),
    .dir        (dir_q),
    .shift_en   (advance),
    .head       (head_unused),
    .next_head  (next_head)
  );

  always_comb begin
    state_d   = state_q;
    out_d     = out_q;
    done_d    = 1'b0;
    bit_idx_d = bit_idx_q;
    pass_d    = pass_q;
    mode_d    = mode_q;
    dir_d     = dir_q;
    rep_d     = rep_q;

    if (LOAD) begin
      // LOAD wins over any end-of-run on the same edge, so no DONE here
      state_d   = ST_RUN;
      mode_d    = MODE;
      dir_d     = DIR;
      rep_d     = REPEAT;
      out_d     = (DIR == DIR_MSB_FIRST) ? LOADED_VALUE[WIDTH-1] : LOADED_VALUE[0];
      bit_idx_d = '0;
      pass_d    = CNT_W'(1);
    end else if (advance) begin
      if (bit_idx_q != C_LAST_IDX) begin
        bit_idx_d = bit_idx_q + IDX_W'(1);
        out_d     = next_head;
      end else begin
        bit_idx_d = '0;
        out_d     = next_head;
        case (mode_q)
          MODE_ROTATE: begin
          end
          MODE_REPEAT: begin
            if (pass_q < rep_max) begin
              pass_d = pass_q + CNT_W'(1);
            end else begin
              state_d = ST_IDLE;
              out_d   = 1'b0;
              done_d  = 1'b1;
            end
          end
          MODE_ONESHOT, 2'd3: begin
            state_d = ST_IDLE;
            out_d   = 1'b0;
            done_d  = 1'b1;
          end
          default: begin
          end
        endcase
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      out_q     <= 1'b0;
      done_q    <= 1'b0;
      bit_idx_q <= '0;
      pass_q    <= '0;
      mode_q    <= MODE_ROTATE;
      dir_q     <= DIR_MSB_FIRST;
      rep_q     <= '0;
    end else begin
      state_q   <= state_d;
      out_q     <= out_d;
      done_q    <= done_d;
      bit_idx_q <= bit_idx_d;
      pass_q    <= pass_d;
      mode_q    <= mode_d;
      dir_q     <= dir_d;
      rep_q     <= rep_d;
    end
  end

  assign OUT     = out_q;
  assign BUSY    = (state_q == ST_RUN);
  assign DONE    = done_q;
  assign BIT_IDX = bit_idx_q;

endmodule

`default_nettype wire

// File: doc/pattern_generator.md
# pattern_generator

Parametrised serial pattern generator, successor to the fixed 16-bit rotating pulse generator in the lab module set. It loads a WIDTH-bit pattern and emits it one bit per enabled clock on `OUT`. It supports MSB- or LSB-first order, free-running, one-shot and counted-repeat modes, clock-enable stall, and a busy/done status pair. It drives LEDs or downstream latch/flip-flop test circuits from the same board clock.

## Interface
- `WIDTH`, 16: pattern length in bits, must be ≥ 2.
- `CNT_W`, 8: width of the repeat counter.
- `CLK` in 1: single clock; all state changes on rising edge.
- `RST` in 1: asynchronous, active-high reset.
- `LOAD` in 1: sampled at rising edge; captures pattern and configuration, then starts a run.
- `LOADED_VALUE` in WIDTH: pattern to capture on `LOAD`.
- `MODE` in 2: captured on `LOAD`.
  - 0 = ROTATE (endless).
  - 1 = ONESHOT.
  - 2 = REPEAT.
  - 3 = reserved, behaves as ONESHOT.
- `DIR` in 1: captured on `LOAD`. 0 = MSB first, 1 = LSB first.
- `REPEAT` in CNT_W: captured on `LOAD`. Pass count for REPEAT mode; 0 is treated as 1.
- `EN` in 1: advance enable. When low, all state holds.
- `OUT` out 1: registered serial output.
- `BUSY` out 1: high while a run is in progress.
- `DONE` out 1: one-cycle pulse when a finite run ends.
- `BIT_IDX` out $clog2(WIDTH): position within the current pass of the bit now on `OUT`, 0..WIDTH-1.

## Operation
- States: IDLE and RUN.
- Reset (async, any time): state IDLE, shift register 0, pass counter 0, `OUT`=0, `BUSY`=0, `DONE`=0, `BIT_IDX`=0.
- **`LOAD` high at an edge, in any state and regardless of `EN`:**
  - Capture pattern, `MODE`, `DIR` and `REPEAT`.
  - Set `OUT` to the first bit (`LOADED_VALUE[WIDTH-1]` if DIR=0, `LOADED_VALUE[0]` if DIR=1).
  - Set `BIT_IDX`=0, pass counter = 1, `BUSY`=1, `DONE`=0, state RUN.
  - A `LOAD` during RUN aborts the current run and restarts; no `DONE` is produced for the aborted run.
- **RUN, `EN`=1, `LOAD`=0, edge:**
  - Rotate the register by one toward the output end (left if DIR=0, right if DIR=1).
  - `OUT` becomes the next bit and `BIT_IDX` increments, wrapping WIDTH-1 → 0.
  - Each wrap closes a pass.
    - ROTATE: wraps forever; never leaves RUN except by reset.
    - ONESHOT: at the edge after `BIT_IDX`=WIDTH-1, go to IDLE with `OUT`=0, `BUSY`=0, `DONE`=1.
    - REPEAT: if pass counter < max(REPEAT,1), wrap and increment the counter. Otherwise end exactly as ONESHOT.
- **RUN, `EN`=0:** register, `OUT`, `BIT_IDX` and pass counter all hold.
- **IDLE:** `OUT`=0, `BUSY`=0, and `EN` is ignored. The captured pattern is retained but not emitted.
- `DONE` is high for exactly one cycle, then 0. It deasserts on the next edge regardless of `EN`.
- The rotation is lossless: after WIDTH enabled advances the register equals the captured pattern.

## Timing
- Load edge t0: bit 0 of the sequence is visible on `OUT` from t0.
- Bit k is visible after the k-th enabled non-load edge; there is no duplicated first bit.
- Finite run of P passes: last bit visible after enabled edge WIDTH·P−1. The next enabled edge gives `DONE`=1, `BUSY`=0, `OUT`=0.
- Latency from `LOAD` to first bit is one edge. `EN` stalls extend all counts cycle-for-cycle.
- Simultaneous `LOAD` and end-of-run at one edge: `LOAD` wins, `DONE` stays 0, new run starts.
- `RST` mid-run clears asynchronously, with no `DONE` pulse.
- REPEAT counter comparison is CNT_W wide. REPEAT=2^CNT_W−1 gives that many passes with no overflow.

## Structure
- Package `pattern_gen_pkg` holds:
  - mode encodings (`MODE_ROTATE`, `MODE_ONESHOT`, `MODE_REPEAT`);
  - state encoding (`ST_IDLE`, `ST_RUN`);
  - direction constants.
- One sub-module, `rotate_reg`: a WIDTH-bit parallel-load, bidirectional rotate register with enable, exposing the output-end bit.
- FSM, bit index and pass counter live in `pattern_generator`.

## Test plan
- Reset mid-run with WIDTH=16, ROTATE, pattern 16'h8001, DIR=0 → `OUT`,`BUSY`,`DONE`,`BIT_IDX` all 0 immediately, before the next edge.
- WIDTH=16, ROTATE, 16'hA5F0, DIR=0, `EN`=1 for 40 edges → `OUT` sequence equals the MSB-first bits repeating with period 16; `BIT_IDX` wraps 15→0; `DONE` never asserts.
- WIDTH=8, ONESHOT, 8'b1100_1010, DIR=1 → `OUT` = 0,1,0,1,0,0,1,1. On the 8th advance edge: `DONE`=1 for one cycle, `BUSY`=0, `OUT`=0.
- WIDTH=4, REPEAT=3, pattern 4'b1000, DIR=0 → 12 bits 1000 1000 1000, then `DONE`. Repeat with REPEAT=0 → one pass only.
- ONESHOT 8'hFF with `EN` low for 5 cycles at `BIT_IDX`=3 → `OUT`/`BIT_IDX` hold; `DONE` arrives exactly 5 cycles later than the unstalled run.
- Mid-run `LOAD` of 8'h0F coinciding with the final-pass end edge → `DONE` stays 0, `BUSY` stays 1, `OUT`=0 (MSB of 8'h0F), `BIT_IDX`=0.
